mem_request_unit: RTL and testbench

CPU-side initiator for the single-port data RAM: accepts one load/store from the datapath and sequences it onto the RAM interface (addr, data_in, write_enable, data_out, busy). Handles byte/halfword/word sizes, performs read-modify-write for sub-word stores, honours RAM busy, and stalls the core until the access completes. Sits between the execute/memory stage and the data RAM.

---
 rtl/mem_request_unit_pkg.sv | 30 +++
 rtl/mem_request_unit_if.sv | 27 ++
 rtl/mem_request_unit_lane_align.sv | 55 +++++
 rtl/mem_request_unit.sv | 155 +++++++++++++++
 tb/tb_mem_request_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_request_unit_pkg.sv
// Shared types and helpers for the data-RAM request unit.
package mem_req_pkg;

  // Access size encoding carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Request sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

  // True when the access cannot be served by a single aligned word access.
  // The reserved size 2'b11 is always treated as illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_WORD: return (off != 2'b00);
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Word-wide bus between the request unit (master) and the data RAM (slave).
// The RAM answers combinationally from mem_addr; mem_busy=1 means the RAM
// cannot complete anything this cycle. A write happens in exactly the cycle
// where mem_write_enable=1 (which the master only drives while mem_busy=0).
interface mem_request_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write_enable;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_write_enable,
    input  mem_rdata,
    input  mem_busy
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_write_enable,
    output mem_rdata,
    output mem_busy
  );
endinterface

// File: rtl/mem_request_unit_lane_align.sv
// Byte-lane steering between a RAM word and the datapath: load extract with
// sign/zero extension, and store merge of a sub-word into an existing word.
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte/half of the word and extend it for loads.
  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    if (size == SZ_BYTE)
      load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
    else if (size == SZ_HALF)
      load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
  end

  // Overlay the right-justified store data onto the addressed lane.
  always_comb begin
    merged_word = word;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd0: merged_word[7:0]   = wdata[7:0];
        2'd1: merged_word[15:8]  = wdata[7:0];
        2'd2: merged_word[23:16] = wdata[7:0];
        2'd3: merged_word[31:24] = wdata[7:0];
        default: merged_word = word;
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) merged_word[31:16] = wdata[15:0];
      else           merged_word[15:0]  = wdata[15:0];
    end else begin
      merged_word = wdata;
    end
  end

endmodule

// File: rtl/mem_request_unit.sv
// CPU-side initiator for the single-port data RAM. Takes one load/store at a
// time from the memory stage, sequences it as read / write / read-modify-write
// onto the RAM bus, and holds the core stalled until completion.
//
// Core handshake: the core raises req_valid with stable request fields and
// keeps them until it sees the one-cycle rsp_valid pulse; stall is low in
// that same cycle so the core advances together with the response. A request
// still presented during the response cycle is only taken the cycle after.
module mem_request_unit
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  mem_request_unit_if.master mem,
  output state_e      dbg_state
);

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  state_e      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        wr_arm_q;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        timed_out;

  mem_lane_align u_align (
    .word        (mem.mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // This busy cycle would be the TIMEOUT-th one charged to the access.
  assign timed_out = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TMO);

  // Write strobe is armed by the FSM in WR and gated by the RAM's busy so a
  // strobe only ever appears in a cycle the RAM will accept it.
  assign mem.mem_addr         = mem_addr_q;
  assign mem.mem_wdata        = mem_wdata_q;
  assign mem.mem_write_enable = wr_arm_q & ~mem.mem_busy;

  // Core hold: pending request in IDLE, or any in-flight RAM phase.
  assign stall     = ((state == IDLE) && req_valid) || (state == RD) || (state == WR);
  assign dbg_state = state;

  // Request sequencer with registered response and RAM-side outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_arm_q    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt_q <= '0;
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            write_q    <= req_write;
            wdata_q    <= req_wdata;
            mem_addr_q <= {req_addr[31:2], 2'b00};
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_write && (req_size == SZ_WORD)) begin
              mem_wdata_q <= req_wdata;
              wr_arm_q    <= 1'b1;
              state       <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (mem.mem_busy) begin
            if (timed_out) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end else if (!write_q) begin
            rsp_rdata <= load_data;
            state     <= DONE;
            rsp_valid <= 1'b1;
          end else begin
            mem_wdata_q <= merged_word;
            wr_arm_q    <= 1'b1;
            state       <= WR;
          end
        end
        WR: begin
          if (mem.mem_busy) begin
            if (timed_out) begin
              wr_arm_q  <= 1'b0;
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end else begin
            wr_arm_q  <= 1'b0;
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          cnt_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a small word RAM model.
module tb_mem_request_unit;
  import mem_req_pkg::*;

  logic        clk;
  logic        nRst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  state_e      dbg_state;

  mem_request_unit_if bus ();

  mem_request_unit #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem          (bus.master),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [31:0] ram [0:255];
  int          wr_cnt;
  int          busy_viol;
  logic [31:0] last_wdata;

  assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.mem_wdata;
      if (bus.mem_busy) busy_viol <= busy_viol + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+#1; that cycle is cycle 0. Busy is held in cycles
  // 1..busy_n. Returns the cycle of rsp_valid (-1 on budget expiry).
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int busy_n, output int lat, output logic err,
                       output logic [31:0] rdata, output logic stall0,
                       output logic stall_done);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    bus.mem_busy = 1'b0;
    lat = -1; err = 1'b0; rdata = '0; stall0 = 1'b0; stall_done = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = stall;
      if (rsp_valid) begin
        lat = c; err = rsp_err; rdata = rsp_rdata; stall_done = stall;
        break;
      end
      @(posedge clk); #1;
      bus.mem_busy = ((c + 1) <= busy_n);
    end
    if (lat < 0) $display("FAIL timeout: no rsp_valid within budget");
    @(posedge clk); #1;
    req_valid    = 1'b0;
    bus.mem_busy = 1'b0;
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  logic        s0, sd;
  int          w0;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[16] = 32'h8899AABB;  // 0x40
    ram[8]  = 32'h11223344;  // 0x20
    wr_cnt = 0; busy_viol = 0; last_wdata = '0;
    n_checks = 0; n_pass = 0;
    nRst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus.mem_busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_we", {31'b0, bus.mem_write_enable}, 32'd0);
    nRst = 1'b1;
    @(posedge clk); #1;

    // Loads from 0x8899AABB at 0x40.
    issue(1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, 0, lat, err, rd, s0, sd);
    check("lb_lat", lat, 32'd2);
    check("lb_err", {31'b0, err}, 32'd0);
    check("lb_data", rd, 32'hFFFFFFAA);
    check("lb_stall0", {31'b0, s0}, 32'd1);
    check("lb_stall_done", {31'b0, sd}, 32'd0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0, 0, lat, err, rd, s0, sd);
    check("lbu_data", rd, 32'h000000AA);
    issue(1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 0, lat, err, rd, s0, sd);
    check("lhu_data", rd, 32'h00008899);
    issue(1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0, 0, lat, err, rd, s0, sd);
    check("lh_hi_data", rd, 32'hFFFF8899);
    issue(1'b0, SZ_HALF, 1'b0, 32'h40, 32'h0, 0, lat, err, rd, s0, sd);
    check("lh_lo_data", rd, 32'hFFFFAABB);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h0, 0, lat, err, rd, s0, sd);
    check("lbu3_data", rd, 32'h00000088);
    check("loads_no_write", wr_cnt, 32'd0);

    // Sub-word stores (read-modify-write).
    issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h000000EF, 0, lat, err, rd, s0, sd);
    check("sb_lat", lat, 32'd3);
    check("sb_wdata", last_wdata, 32'hEF000000);
    check("sb_writes", wr_cnt, 32'd1);
    check("sb_rdata_kept", rd, 32'h00000088);
    issue(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h1234BEEF, 0, lat, err, rd, s0, sd);
    check("sh_lat", lat, 32'd3);
    check("sh_ram", ram[8], 32'hBEEF3344);

    // Word store then load.
    w0 = wr_cnt;
    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678, 0, lat, err, rd, s0, sd);
    check("sw_lat", lat, 32'd2);
    check("sw_writes", wr_cnt - w0, 32'd1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, lat, err, rd, s0, sd);
    check("lw_lat", lat, 32'd2);
    check("lw_data", rd, 32'h12345678);

    // Misaligned accesses.
    w0 = wr_cnt;
    issue(1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, 0, lat, err, rd, s0, sd);
    check("mis_lw_lat", lat, 32'd1);
    check("mis_lw_err", {31'b0, err}, 32'd1);
    check("mis_lw_rdata", rd, 32'h12345678);
    issue(1'b1, SZ_HALF, 1'b0, 32'h21, 32'hFFFF, 0, lat, err, rd, s0, sd);
    check("mis_sh_lat", lat, 32'd1);
    check("mis_sh_err", {31'b0, err}, 32'd1);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, lat, err, rd, s0, sd);
    check("bad_size_err", {31'b0, err}, 32'd1);
    check("mis_no_write", wr_cnt - w0, 32'd0);

    // Busy stretching a word store.
    w0 = wr_cnt;
    issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFEF00D, 3, lat, err, rd, s0, sd);
    check("busy_sw_lat", lat, 32'd5);
    check("busy_sw_err", {31'b0, err}, 32'd0);
    check("busy_sw_writes", wr_cnt - w0, 32'd1);
    check("busy_sw_ram", ram[5], 32'hCAFEF00D);
    check("we_while_busy", busy_viol, 32'd0);

    // Timeout: busy far longer than TIMEOUT.
    w0 = wr_cnt;
    issue(1'b1, SZ_WORD, 1'b0, 32'h18, 32'hA5A5A5A5, 20, lat, err, rd, s0, sd);
    check("tmo_lat", lat, 32'd17);
    check("tmo_err", {31'b0, err}, 32'd1);
    check("tmo_writes", wr_cnt - w0, 32'd0);
    check("tmo_ram", ram[6], 32'h0);
    check("tmo_rdata_kept", rd, 32'h12345678);

    // Reset while a store is stuck in WR.
    w0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.mem_busy = 1'b1;
    @(posedge clk); #1;
    check("mid_state_wr", {30'b0, dbg_state}, {30'b0, WR});
    req_valid = 1'b0;
    nRst = 1'b0;
    #1;
    check("mid_we", {31'b0, bus.mem_write_enable}, 32'd0);
    check("mid_addr", bus.mem_addr, 32'd0);
    check("mid_wdata", bus.mem_wdata, 32'd0);
    check("mid_stall", {31'b0, stall}, 32'd0);
    bus.mem_busy = 1'b0;
    @(posedge clk); #1;
    nRst = 1'b1;
    @(negedge clk);
    check("mid_idle", {30'b0, dbg_state}, {30'b0, IDLE});
    check("mid_ram", ram[12], 32'h0);
    check("mid_writes", wr_cnt - w0, 32'd0);
    check("mid_rdata_cleared", rsp_rdata, 32'd0);
    @(posedge clk); #1;

    // Access works normally after the abort.
    issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 0, lat, err, rd, s0, sd);
    check("post_rst_lat", lat, 32'd2);
    check("post_rst_data", rd, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
